// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg : shared state encoding and width helpers for the round engine.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package game_pkg;

  typedef enum logic [1:0] {
    ST_LOBBY = 2'd0,
    ST_PLAY  = 2'd1,
    ST_OVER  = 2'd2
  } game_state_e;

  function automatic int box_w(input int num_boxes);
    return $clog2(num_boxes + 1);
  endfunction

  function automatic int time_w(input int round_secs);
    return $clog2(round_secs + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hit_debouncer.sv
// ---------------------------------------------------------------------------
// hit_debouncer : single-shot strike detector on a registered box address.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hit_debouncer #(
  parameter int BOX_W    = 3,
  parameter int DEBOUNCE = 250_000
) (
  input  logic             CLOCK_50,
  input  logic             resetn,
  input  logic [BOX_W-1:0] sample,
  output logic             strike,
  output logic [BOX_W-1:0] strike_addr
);

  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE);

  logic [BOX_W-1:0] prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             armed_q, armed_d;

  assign strike      = armed_q && (cnt_q == CNT_MAX);
  assign strike_addr = prev_q;

  // Only an idle (zero) sample re-arms; switching boxes just restarts the count.
  always_comb begin
    prev_d  = sample;
    cnt_d   = cnt_q;
    armed_d = armed_q;
    if (sample == '0) begin
      cnt_d   = '0;
      armed_d = 1'b1;
    end else begin
      if (strike) armed_d = 1'b0;
      if (sample != prev_q) cnt_d = CNT_W'(1);
      else if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      prev_q  <= '0;
      cnt_q   <= '0;
      armed_q <= 1'b1;
    end else begin
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/game_round_engine.sv
// ---------------------------------------------------------------------------
// game_round_engine : lobby/play/over round FSM with timed scoring of strikes.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module game_round_engine
  import game_pkg::*;
#(
  parameter int NUM_BOXES    = 6,
  parameter int SCORE_W      = 11,
  parameter int TICK_DIV     = 50_000_000,
  parameter int ROUND_SECS   = 60,
  parameter int DEBOUNCE     = 250_000,
  parameter int SOUND_CYCLES = 25_000_000,
  parameter bit PENALTY_EN   = 1'b1,
  localparam int BOX_W       = box_w(NUM_BOXES),
  localparam int TIME_W      = time_w(ROUND_SECS)
) (
  input  logic               CLOCK_50,
  input  logic               resetn,
  input  logic               start_game,
  input  logic [BOX_W-1:0]   sensor_addr,
  input  logic [BOX_W-1:0]   target_addr,
  output logic [SCORE_W-1:0] score,
  output logic [TIME_W-1:0]  time_left,
  output logic [1:0]         state,
  output logic               lobby_sound,
  output logic               hit_sound,
  output logic               next_target,
  output logic               game_over
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SND_W  = $clog2(SOUND_CYCLES + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [TIME_W-1:0] TIME_FULL = TIME_W'(ROUND_SECS);
  localparam logic [BOX_W-1:0]  MAX_BOX   = BOX_W'(NUM_BOXES);
  localparam logic [SND_W-1:0]  SND_LOAD  = SND_W'(SOUND_CYCLES);

  game_state_e        state_q, state_d;
  logic [BOX_W-1:0]   sens_q, sens_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [TIME_W-1:0]  time_q, time_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SND_W-1:0]   snd_q, snd_d;
  logic               nt_q, nt_d;
  logic               lobby_q, lobby_d;
  logic               over_q, over_d;

  logic               strike;
  logic [BOX_W-1:0]   strike_addr;

  hit_debouncer #(
    .BOX_W    (BOX_W),
    .DEBOUNCE (DEBOUNCE)
  ) u_debouncer (
    .CLOCK_50    (CLOCK_50),
    .resetn      (resetn),
    .sample      (sens_q),
    .strike      (strike),
    .strike_addr (strike_addr)
  );

  always_comb begin
    sens_d  = (sensor_addr > MAX_BOX) ? '0 : sensor_addr;
    state_d = state_q;
    tick_d  = tick_q;
    time_d  = time_q;
    score_d = score_q;
    snd_d   = (snd_q != '0) ? snd_q - 1'b1 : snd_q;
    nt_d    = 1'b0;

    unique case (state_q)
      ST_LOBBY: begin
        if (start_game) begin
          state_d = ST_PLAY;
          score_d = '0;
          time_d  = TIME_FULL;
          tick_d  = '0;
        end
      end
      ST_PLAY: begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          time_d = time_q - 1'b1;
          if (time_q == TIME_W'(1)) state_d = ST_OVER;
        end else begin
          tick_d = tick_q + 1'b1;
        end
        // Scoring is independent of the tick so a strike on the final tick still counts.
        if (strike) begin
          if ((target_addr != '0) && (strike_addr == target_addr)) begin
            nt_d  = 1'b1;
            snd_d = SND_LOAD;
            if (score_q != '1) score_d = score_q + 1'b1;
          end else if (PENALTY_EN && (score_q != '0)) begin
            score_d = score_q - 1'b1;
          end
        end
      end
      ST_OVER: begin
        if (start_game) state_d = ST_LOBBY;
      end
      default: state_d = ST_LOBBY;
    endcase

    lobby_d = (state_d == ST_LOBBY);
    over_d  = (state_d == ST_OVER);
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_LOBBY;
      sens_q  <= '0;
      tick_q  <= '0;
      time_q  <= TIME_FULL;
      score_q <= '0;
      snd_q   <= '0;
      nt_q    <= 1'b0;
      lobby_q <= 1'b1;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sens_q  <= sens_d;
      tick_q  <= tick_d;
      time_q  <= time_d;
      score_q <= score_d;
      snd_q   <= snd_d;
      nt_q    <= nt_d;
      lobby_q <= lobby_d;
      over_q  <= over_d;
    end
  end

  assign score       = score_q;
  assign time_left   = time_q;
  assign state       = state_q;
  assign lobby_sound = lobby_q;
  assign hit_sound   = (snd_q != '0);
  assign next_target = nt_q;
  assign game_over   = over_q;

endmodule

`default_nettype wire

// File: tb/tb_game_round_engine.sv
// ---------------------------------------------------------------------------
// tb_game_round_engine : scoreboard bench for the round engine.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_game_round_engine;

  logic       clk;
  logic       resetn;
  logic       start_game;
  logic [2:0] sensor_addr;
  logic [2:0] target_addr;
  logic [3:0] score;
  logic [1:0] time_left;
  logic [1:0] state;
  logic       lobby_sound;
  logic       hit_sound;
  logic       next_target;
  logic       game_over;

  // Longer-round instance so sixteen-plus hits fit inside one round.
  logic       start_b;
  logic [2:0] sensor_b;
  logic [2:0] target_b;
  logic [3:0] score_b;
  logic [3:0] time_b;
  logic [1:0] state_b;
  logic       lobby_b;
  logic       hit_b;
  logic       nt_b;
  logic       over_b;

  game_round_engine #(
    .NUM_BOXES(6), .SCORE_W(4), .TICK_DIV(10), .ROUND_SECS(3),
    .DEBOUNCE(4), .SOUND_CYCLES(8), .PENALTY_EN(1'b1)
  ) dut (
    .CLOCK_50(clk), .resetn(resetn), .start_game(start_game),
    .sensor_addr(sensor_addr), .target_addr(target_addr),
    .score(score), .time_left(time_left), .state(state),
    .lobby_sound(lobby_sound), .hit_sound(hit_sound),
    .next_target(next_target), .game_over(game_over)
  );

  game_round_engine #(
    .NUM_BOXES(6), .SCORE_W(4), .TICK_DIV(10), .ROUND_SECS(10),
    .DEBOUNCE(4), .SOUND_CYCLES(8), .PENALTY_EN(1'b1)
  ) dut_sat (
    .CLOCK_50(clk), .resetn(resetn), .start_game(start_b),
    .sensor_addr(sensor_b), .target_addr(target_b),
    .score(score_b), .time_left(time_b), .state(state_b),
    .lobby_sound(lobby_b), .hit_sound(hit_b),
    .next_target(nt_b), .game_over(over_b)
  );

  typedef struct {
    logic [3:0] score;
    logic       nt;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   s_edge  = 0;
  int   nt_cnt  = 0;
  int   kb      = 0;
  logic [3:0] last_score = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of run");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [3:0] s, input logic nt);
    exp_t e;
    e.score = s;
    e.nt    = nt;
    sb_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic start_pulse();
    start_game = 1'b1;
    step();
    start_game = 1'b0;
    s_edge = cyc;
  endtask

  task automatic goto(input int n);
    while (cyc < s_edge + n) step();
  endtask

  // Address held for four sampling edges then released; score settles on the 6th edge.
  task automatic do_strike(input logic [2:0] a, input logic [2:0] t);
    sensor_addr = a;
    target_addr = t;
    repeat (4) step();
    sensor_addr = '0;
    repeat (2) step();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!resetn) begin
      last_score = score;
    end else begin
      if (next_target) nt_cnt++;
      if ((score != last_score) || next_target) begin
        if (sb_q.size() == 0) begin
          check("sb_extra", sb_q.size(), 1);
        end else begin
          e = sb_q.pop_front();
          check("sb_score", score, e.score);
          check("sb_nt", next_target, e.nt);
        end
        last_score = score;
      end
      if (nt_b) begin
        kb++;
        check("sat_score", score_b, (kb > 15) ? 15 : kb);
      end
    end
  end

  initial begin
    int hs;
    int nt0;
    resetn = 1'b0; start_game = 1'b0; sensor_addr = '0; target_addr = '0;
    start_b = 1'b0; sensor_b = '0; target_b = 3'd4;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", state, 0);
    check("rst_score", score, 0);
    check("rst_time", time_left, 3);
    check("rst_lobby", lobby_sound, 1);
    check("rst_hs", hit_sound, 0);
    check("rst_nt", next_target, 0);
    check("rst_over", game_over, 0);
    resetn = 1'b1;
    step();

    // Round 1: latency, pulse widths, miss penalty, out-of-range sensor.
    start_pulse();
    check("play_state", state, 1);
    check("play_time", time_left, 3);
    check("play_lobby", lobby_sound, 0);
    nt0 = nt_cnt;
    hs  = 0;
    push_exp(4'd1, 1'b1);
    sensor_addr = 3'd3;
    target_addr = 3'd3;
    for (int e = 1; e <= 16; e++) begin
      step();
      if (e == 10) sensor_addr = '0;
      if (hit_sound) hs++;
      if (e == 5) check("lat_before", score, 0);
      if (e == 6) begin
        check("lat_score", score, 1);
        check("lat_nt", next_target, 1);
      end
      if (e == 7) check("nt_width", next_target, 0);
    end
    check("hs_len", hs, 8);
    check("one_hit", nt_cnt - nt0, 1);
    push_exp(4'd0, 1'b0);
    do_strike(3'd2, 3'd5);
    check("miss_dec", score, 0);
    nt0 = nt_cnt;
    do_strike(3'd7, 3'd7);
    check("oob_score", score, 0);
    check("oob_nt", nt_cnt - nt0, 0);
    goto(30);
    check("r1_over", state, 2);
    check("r1_go", game_over, 1);
    check("r1_time", time_left, 0);
    start_pulse();
    check("r1_lobby_state", state, 0);
    check("r1_lobby_snd", lobby_sound, 1);

    // Round 2: countdown with an ignored start in PLAY.
    start_pulse();
    goto(9);  check("t9", time_left, 3);
    goto(10); check("t10", time_left, 2);
    goto(15);
    start_pulse();
    s_edge = s_edge - 16;
    check("start_ignored", state, 1);
    goto(20); check("t20", time_left, 1);
    goto(29);
    check("t29", time_left, 1);
    check("t29_state", state, 1);
    check("t29_go", game_over, 0);
    goto(30);
    check("t30", time_left, 0);
    check("t30_state", state, 2);
    check("t30_go", game_over, 1);
    start_pulse();
    check("r2_lobby", state, 0);
    check("r2_lobby_snd", lobby_sound, 1);
    check("r2_go_clr", game_over, 0);

    // Round 3: miss at zero, then a strike landing on the final tick.
    start_pulse();
    do_strike(3'd2, 3'd5);
    check("miss_floor", score, 0);
    goto(24);
    push_exp(4'd1, 1'b1);
    sensor_addr = 3'd3;
    target_addr = 3'd3;
    repeat (4) step();
    sensor_addr = '0;
    goto(29);
    check("fin_pre_score", score, 0);
    check("fin_pre_state", state, 1);
    goto(30);
    check("fin_score", score, 1);
    check("fin_state", state, 2);
    check("fin_nt", next_target, 1);
    goto(37); check("hs_over_hi", hit_sound, 1);
    goto(38); check("hs_over_lo", hit_sound, 0);
    start_pulse();
    check("lobby_hold", score, 1);
    nt0 = nt_cnt;
    do_strike(3'd3, 3'd3);
    check("lobby_strike_score", score, 1);
    check("lobby_strike_nt", nt_cnt - nt0, 0);

    // Round 4: asynchronous reset while hit_sound is active.
    push_exp(4'd0, 1'b0);
    start_pulse();
    check("r4_clear", score, 0);
    push_exp(4'd1, 1'b1);
    do_strike(3'd3, 3'd3);
    goto(8);
    check("r4_hs", hit_sound, 1);
    resetn = 1'b0;
    #1;
    check("arst_state", state, 0);
    check("arst_score", score, 0);
    check("arst_time", time_left, 3);
    check("arst_lobby", lobby_sound, 1);
    check("arst_hs", hit_sound, 0);
    check("arst_nt", next_target, 0);
    check("arst_go", game_over, 0);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    nt0 = nt_cnt;
    hs  = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (hit_sound) hs++;
    end
    check("post_rst_nt", nt_cnt - nt0, 0);
    check("post_rst_hs", hs, 0);
    check("post_rst_state", state, 0);

    // Saturation on the long-round instance.
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    for (int h = 0; h < 17; h++) begin
      sensor_b = 3'd4;
      repeat (4) step();
      sensor_b = '0;
      step();
    end
    repeat (4) step();
    check("sat_final", score_b, 15);
    check("sat_hits", kb, 17);
    check("sat_state", state_b, 1);

    check("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
